// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard.
// Tracks in-flight loads for LOAD_LAT stages after ID. It stalls IF/ID and
// injects an EX bubble while an ID source depends on a load whose data cannot
// yet be forwarded.
// Optional feature: define LOAD_USE_PERF_EN to build the saturating stall
// cycle counter on stall_cnt. Without the macro, stall_cnt is tied to zero.
module load_use_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_is_store,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              pipe_hold,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Entry 0 is the instruction in EX; entry LOAD_LAT-1 is the oldest tracked load.
  logic [LOAD_LAT-1:0] ent_v;
  logic [REG_AW-1:0]   ent_rd [LOAD_LAT];

  logic rs1_hit;
  logic rs2_hit;
  logic issue;
  logic new_v;

  assign issue = id_valid & ~stall & ~flush & ~pipe_hold;
  // Register x0 is never a real dependency, so loads to x0 create no entry.
  assign new_v = issue & id_is_load & (id_rd != {REG_AW{1'b0}});

  // Advance the load tracker each unfrozen cycle; freeze it under pipe_hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_v <= {LOAD_LAT{1'b0}};
      for (int i = 0; i < LOAD_LAT; i++) begin
        ent_rd[i] <= {REG_AW{1'b0}};
      end
    end else if (!pipe_hold) begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        ent_v[i]  <= ent_v[i-1];
        ent_rd[i] <= ent_rd[i-1];
      end
      ent_v[0]  <= new_v;
      ent_rd[0] <= id_rd;
    end else begin
      ent_v <= ent_v;
    end
  end

  // Compare ID sources with every tracked load. Store data (rs2) can be
  // forwarded from the oldest stage, so that stage never blocks a store's rs2.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (ent_v[k] && (ent_rd[k] == id_rs1)) begin
        rs1_hit = 1'b1;
      end else begin
        rs1_hit = rs1_hit;
      end
      if (ent_v[k] && (ent_rd[k] == id_rs2) &&
          !(id_is_store && (k == LOAD_LAT - 1))) begin
        rs2_hit = 1'b1;
      end else begin
        rs2_hit = rs2_hit;
      end
    end
  end

  // Hazard outputs. These are combinational because the stall must act in the
  // same cycle. They are forced low while reset is asserted.
  always_comb begin
    if (rst || !id_valid || flush) begin
      stall = 1'b0;
    end else begin
      stall = (rs1_hit & id_rs1_used & (id_rs1 != {REG_AW{1'b0}})) |
              (rs2_hit & id_rs2_used & (id_rs2 != {REG_AW{1'b0}}));
    end
    bubble = stall & ~pipe_hold;
    busy   = |ent_v;
  end

`ifdef LOAD_USE_PERF_EN
  logic [CNT_W-1:0] cnt;

  // Count bubble cycles and saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (bubble && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign stall_cnt = cnt;
`else
  assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/load_use_scoreboard.md
LOAD_USE_SCOREBOARD -- requirements
Module: load_use_scoreboard

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, meaning the number of pipeline stages after ID before load data is forwardable (legal 1..4).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the stall performance counter.
REQ-003 SHALL have parameter REG_AW, default 5, meaning the register-index width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 id_valid  input  1  ID holds a valid instruction.
REQ-007 id_rs1, id_rs2  input  REG_AW each  ID source indices.
REQ-008 id_rs1_used, id_rs2_used  input  1 each  source actually read by the ID opcode.
REQ-009 id_is_store  input  1  ID instruction is a store, so rs2 is store data.
REQ-010 id_is_load  input  1  ID instruction is a load.
REQ-011 id_rd  input  REG_AW  ID destination index.
REQ-012 pipe_hold  input  1  downstream memory wait; whole pipeline frozen.
REQ-013 flush  input  1  control-transfer squash of the ID instruction.
REQ-014 stall  output  1  freeze IF/ID.
REQ-015 bubble  output  1  inject NOP into EX this cycle.
REQ-016 busy  output  1  at least one scoreboard entry valid.
REQ-017 stall_cnt  output  CNT_W  count of stall cycles (see Configuration).

Function
REQ-018 SHALL hold LOAD_LAT entries {v, rd}; entry 0 = instruction in EX, entry LOAD_LAT-1 = oldest tracked load.
REQ-019 issue = id_valid & ~stall & ~flush & ~pipe_hold.
REQ-020 When pipe_hold=0, entries SHALL shift on each clk: entry[i] <= entry[i-1]; entry[0] <= {issue & id_is_load & (id_rd!=0), id_rd}.
REQ-021 When pipe_hold=1, all entries SHALL hold their values.
REQ-022 Source match on entry k: entry[k].v & srcX_used & srcX!=0 & srcX==entry[k].rd.
REQ-023 stall SHALL be 1 when id_valid & ~flush and any rs1 or rs2 match exists, except per REQ-024; combinational, same cycle.
REQ-024 An rs2 match with id_is_store=1 SHALL NOT stall when its only matching entry is k=LOAD_LAT-1 (memory-stage store-data forwarding); matches in younger entries SHALL still stall.
REQ-025 An rs1 match SHALL always stall, including for stores.
REQ-026 bubble SHALL equal stall & ~pipe_hold.
REQ-027 flush SHALL have priority: stall=0, bubble=0, entry[0] receives v=0 on that edge; older entries shift normally.
REQ-028 A stall SHALL persist at most LOAD_LAT cycles without pipe_hold, ending the cycle the matching load leaves entry LOAD_LAT-1.
REQ-029 busy SHALL be the OR of all entry valid bits.

Reset
REQ-030 rst=1 SHALL asynchronously clear all entry v and rd to 0 and stall_cnt to 0.
REQ-031 During reset, stall, bubble and busy SHALL be 0; reset asserted mid-stall SHALL drop stall immediately.
REQ-032 The first edge after rst deasserts SHALL operate normally.

Configuration
REQ-033 Macro LOAD_USE_PERF_EN defined: stall_cnt SHALL increment by 1 on each edge where bubble=1, saturating at all-ones.
REQ-034 LOAD_USE_PERF_EN undefined: stall_cnt SHALL be constant 0 and no counter flops SHALL be instantiated.

Verification
REQ-035 LOAD_LAT=1: issue load rd=x5, then add rs1=x5 -> stall=1 and bubble=1 for exactly 1 cycle, then issue.
REQ-036 LOAD_LAT=3: load x7, then sub rs2=x7 -> stall for 3 cycles; store rs2=x7 -> stall for 2 cycles (entry 2 forwarded); store rs1=x7 -> stall for 3 cycles.
REQ-037 Load rd=x0, then use rs1=x0 -> stall=0, busy=0.
REQ-038 Load x9 issued, then dependent in ID with pipe_hold=1 for 4 cycles -> stall=1, bubble=0, entries frozen; after pipe_hold drops, stall=1 for LOAD_LAT more cycles.
REQ-039 Load x4 in ID with flush=1 -> no entry created, busy stays 0; rst pulsed mid-stall -> stall=0 asynchronously, stall_cnt=0.
REQ-040 LOAD_USE_PERF_EN defined, CNT_W=2: 5 bubble cycles -> stall_cnt=3 (saturated); undefined -> stall_cnt=0.
